approx_mul_seq: RTL
===================

APPROX_MUL_SEQ -- requirements
Module: approx_mul_seq

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits; product is 2*WIDTH bits.
REQ-002 Parameter TRUNC, default 2: number of low product columns (0..2*WIDTH-1) whose partial-product bits are dropped in approximate mode.
REQ-003 Parameter ET, default 8: error threshold, absolute product error.
REQ-004 Port interface:
- clk, input, 1: sole clock; all logic on rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- in_valid, input, 1: operands valid.
- in_ready, output, 1: block accepts operands.
- in_a, input, WIDTH: multiplicand, unsigned.
- in_b, input, WIDTH: multiplier, unsigned.
- approx_en, input, 1: 1 = truncated mode, 0 = exact mode; sampled at accept.
- out_valid, output, 1: product valid.
- out_ready, input, 1: consumer accepts product.
- out_p, output, 2*WIDTH: product.
- err_abs, output, 2*WIDTH: |exact - out_p| for the current result.
- err_viol, output, 1: err_abs > ET for the current result.
- viol_cnt, output, 16: saturating count of violating results.

Function
REQ-005 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-006 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-007 In IDLE, an in_valid&&in_ready edge SHALL capture in_a, in_b and approx_en, clear the accumulator and the bit index, and enter BUSY.
REQ-008 In BUSY, each cycle SHALL process multiplier bit b[idx]: if set, add (a<<idx) to the accumulator, then increment idx.
REQ-009 In approximate mode, partial-product bits in columns < TRUNC SHALL be masked to 0 before addition; exact mode SHALL apply no mask.
REQ-010 BUSY SHALL last exactly WIDTH cycles, then enter DONE; out_valid SHALL rise WIDTH+1 edges after the accepting edge.
REQ-011 The accumulator SHALL be 2*WIDTH bits wide and SHALL never overflow.
REQ-012 In DONE, out_p, err_abs and err_viol SHALL hold stable until out_valid&&out_ready, which SHALL return the FSM to IDLE.
REQ-013 No new operand SHALL be accepted on the release edge; the earliest next accept is the following edge.
REQ-014 Operand and approx_en changes while not in IDLE SHALL have no effect.
REQ-015 An rst_n=0 edge in any state SHALL abandon the operation immediately.

Reset
REQ-016 On an rst_n=0 edge the block SHALL apply:
- FSM to IDLE;
- out_valid=0, in_ready=1 after reset;
- out_p=0, err_abs=0, err_viol=0;
- viol_cnt=0, accumulators and index cleared.

Configuration
REQ-017 Macro APPROX_MUL_ERR_MON_EN defined: a parallel exact accumulator SHALL run alongside the approximate one, with no added latency.
- err_abs and err_viol SHALL be registered on entry to DONE.
- viol_cnt SHALL increment, saturating at 0xFFFF, once per result with err_viol=1.
REQ-018 Macro APPROX_MUL_ERR_MON_EN undefined: err_abs, err_viol and viol_cnt SHALL be constant 0 and no exact accumulator SHALL be synthesised.

Structure
REQ-019 The shared package approx_pkg SHALL hold:
- the state enum (IDLE, BUSY, DONE);
- the viol_cnt width constant (16);
- a column-mask function giving a 2*WIDTH mask from TRUNC.
REQ-020 The error monitor SHALL be the sub-module approx_err_mon: exact accumulator, absolute difference, threshold compare and saturating counter.
REQ-021 RTL size SHALL be 120-400 lines.

Verification
REQ-022 Directed scenarios; all use WIDTH=4, TRUNC=2 and the monitor enabled, with ET as noted.
- a=3, b=3, approx_en=1, ET=8 -> out_p=4, err_abs=5, err_viol=0, out_valid 5 edges after accept.
- a=15, b=15, approx_en=1, ET=4 -> out_p=220, err_abs=5, err_viol=1, viol_cnt=1.
- a=15, b=15, approx_en=0 -> out_p=225, err_abs=0, err_viol=0.
- out_ready held 0 for 10 cycles in DONE -> out_p stable, in_ready=0 and in_valid ignored; after release, next accept one edge later.
- rst_n pulsed low in BUSY -> next edge IDLE, out_valid=0, in_ready=1, viol_cnt=0.
- 65540 violating results -> viol_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/approx_pkg.sv
// Shared types and helpers for the approximate sequential multiplier.
package approx_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int VIOL_CNT_W = 16;

  // Keeps product columns >= trunc. Callers slice the low 2*WIDTH bits.
  function automatic logic [63:0] col_mask(input int trunc);
    logic [63:0] m;
    m = '1;
    for (int i = 0; i < 64; i++) begin
      if (i < trunc) m[i] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/approx_err_mon.sv
// Error monitor: exact shadow accumulator, |exact - approx|, threshold compare
// and a saturating violation counter. Results latch on the last BUSY step.
module approx_err_mon
  import approx_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ET    = 8,
  parameter int CNT_W = VIOL_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_step,
  input  logic                 i_last,
  input  logic [2*WIDTH-1:0]   i_pp_exact,
  input  logic [2*WIDTH-1:0]   i_approx_next,
  output logic [2*WIDTH-1:0]   o_err_abs,
  output logic                 o_err_viol,
  output logic [CNT_W-1:0]     o_viol_cnt
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    r_exact;
  logic [PW-1:0]    r_err_abs;
  logic             r_err_viol;
  logic [CNT_W-1:0] r_viol_cnt;
  logic [PW-1:0]    w_exact_next;
  logic [PW-1:0]    w_diff;
  logic             w_viol;

  assign w_exact_next = r_exact + i_pp_exact;
  assign w_diff       = (w_exact_next >= i_approx_next) ? (w_exact_next - i_approx_next)
                                                        : (i_approx_next - w_exact_next);
  assign w_viol       = 64'(w_diff) > 64'(ET);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_exact    <= '0;
      r_err_abs  <= '0;
      r_err_viol <= 1'b0;
      r_viol_cnt <= '0;
    end else begin
      if (i_clr) begin
        r_exact <= '0;
      end else if (i_step) begin
        r_exact <= w_exact_next;
      end
      // Final step: compare against the approximate sum landing this same edge.
      if (i_step && i_last) begin
        r_err_abs  <= w_diff;
        r_err_viol <= w_viol;
        if (w_viol && (r_viol_cnt != '1)) r_viol_cnt <= r_viol_cnt + 1'b1;
      end
    end
  end

  assign o_err_abs  = r_err_abs;
  assign o_err_viol = r_err_viol;
  assign o_viol_cnt = r_viol_cnt;

endmodule

// File: rtl/approx_mul_seq.sv
// Sequential shift-add multiplier with optional low-column truncation.
// Define APPROX_MUL_ERR_MON_EN to build the exact-vs-approx error monitor.
module approx_mul_seq
  import approx_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int TRUNC = 2,
  parameter int ET    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  input  logic                  approx_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*WIDTH-1:0]    out_p,
  output logic [2*WIDTH-1:0]    err_abs,
  output logic                  err_viol,
  output logic [VIOL_CNT_W-1:0] viol_cnt
);

  localparam int              PW         = 2 * WIDTH;
  localparam int              IW         = $clog2(WIDTH + 1);
  localparam logic [63:0]     MASK_ALL   = col_mask(TRUNC);
  localparam logic [PW-1:0]   TRUNC_MASK = MASK_ALL[PW-1:0];

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_approx;
  logic [PW-1:0]    r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [PW-1:0]    r_acc;
  logic [IW-1:0]    r_idx;

  logic             w_accept;
  logic             w_last;
  logic [PW-1:0]    w_pp_exact;
  logic [PW-1:0]    w_pp;
  logic [PW-1:0]    w_acc_next;

  // r_a_sh tracks a<<idx and r_b_sh[0] tracks b[idx], avoiding a variable shifter.
  assign w_accept   = (r_state == IDLE) && in_valid;
  assign w_last     = (r_idx == IW'(WIDTH - 1));
  assign w_pp_exact = r_b_sh[0] ? r_a_sh : '0;
  assign w_pp       = r_approx ? (w_pp_exact & TRUNC_MASK) : w_pp_exact;
  assign w_acc_next = r_acc + w_pp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_approx    <= 1'b0;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a_sh     <= PW'(in_a);
            r_b_sh     <= in_b;
            r_approx   <= approx_en;
            r_acc      <= '0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          r_acc  <= w_acc_next;
          r_a_sh <= r_a_sh << 1;
          r_b_sh <= r_b_sh >> 1;
          r_idx  <= r_idx + 1'b1;
          if (w_last) r_state <= DONE;
        end
        DONE: begin
          // First DONE cycle lets the monitor result settle before out_valid rises.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_p     = r_acc;

`ifdef APPROX_MUL_ERR_MON_EN
  approx_err_mon #(
    .WIDTH (WIDTH),
    .ET    (ET),
    .CNT_W (VIOL_CNT_W)
  ) u_err_mon (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clr         (w_accept),
    .i_step        (r_state == BUSY),
    .i_last        (w_last),
    .i_pp_exact    (w_pp_exact),
    .i_approx_next (w_acc_next),
    .o_err_abs     (err_abs),
    .o_err_viol    (err_viol),
    .o_viol_cnt    (viol_cnt)
  );
`else
  assign err_abs  = '0;
  assign err_viol = 1'b0;
  assign viol_cnt = '0;
`endif

endmodule
